// File: rtl/bjp_resolve_sched_if.sv
// Port bundle for bjp_resolve_sched: redirect requests/outputs, predictor-update FIFO and issue stall.
// Defining BJP_SCHED_STAT_EN adds the flush/drop statistics counters to the bundle.
interface bjp_resolve_sched_if #(
    parameter int NUM_BJP      = 2,
    parameter int ROB_ID_WIDTH = 8,
    parameter int PC_WIDTH     = 32,
    parameter int UPD_WIDTH    = 85
);
    logic                            i_csr_trap_flush;
    logic [NUM_BJP-1:0]              i_bjp_mis_flush;
    logic [NUM_BJP*ROB_ID_WIDTH-1:0] i_bjp_mis_rob_id;
    logic [NUM_BJP*PC_WIDTH-1:0]     i_bjp_mis_addr;
    logic                            i_exu_ls_flush;
    logic [ROB_ID_WIDTH-1:0]         i_exu_ls_rob_id;
    logic [PC_WIDTH-1:0]             i_exu_ls_addr;
    logic                            o_flush_vld;
    logic [ROB_ID_WIDTH-1:0]         o_flush_rob_id;
    logic [PC_WIDTH-1:0]             o_flush_addr;
    logic                            o_flush_is_ls;
    logic [NUM_BJP-1:0]              i_bjp_upd_vld;
    logic [NUM_BJP*ROB_ID_WIDTH-1:0] i_bjp_upd_rob_id;
    logic [NUM_BJP*UPD_WIDTH-1:0]    i_bjp_upd_bus;
    logic                            o_iq_upd_vld;
    logic [UPD_WIDTH-1:0]            o_iq_upd_bus;
    logic                            i_iq_upd_rdy;
    logic                            o_bjp_issue_stall;
`ifdef BJP_SCHED_STAT_EN
    logic [31:0]                     o_stat_flush_cnt;
    logic [31:0]                     o_stat_drop_cnt;

    modport slave (
        input  i_csr_trap_flush, i_bjp_mis_flush, i_bjp_mis_rob_id, i_bjp_mis_addr,
        input  i_exu_ls_flush, i_exu_ls_rob_id, i_exu_ls_addr,
        input  i_bjp_upd_vld, i_bjp_upd_rob_id, i_bjp_upd_bus, i_iq_upd_rdy,
        output o_flush_vld, o_flush_rob_id, o_flush_addr, o_flush_is_ls,
        output o_iq_upd_vld, o_iq_upd_bus, o_bjp_issue_stall,
        output o_stat_flush_cnt, o_stat_drop_cnt
    );
    modport master (
        output i_csr_trap_flush, i_bjp_mis_flush, i_bjp_mis_rob_id, i_bjp_mis_addr,
        output i_exu_ls_flush, i_exu_ls_rob_id, i_exu_ls_addr,
        output i_bjp_upd_vld, i_bjp_upd_rob_id, i_bjp_upd_bus, i_iq_upd_rdy,
        input  o_flush_vld, o_flush_rob_id, o_flush_addr, o_flush_is_ls,
        input  o_iq_upd_vld, o_iq_upd_bus, o_bjp_issue_stall,
        input  o_stat_flush_cnt, o_stat_drop_cnt
    );
`else
    modport slave (
        input  i_csr_trap_flush, i_bjp_mis_flush, i_bjp_mis_rob_id, i_bjp_mis_addr,
        input  i_exu_ls_flush, i_exu_ls_rob_id, i_exu_ls_addr,
        input  i_bjp_upd_vld, i_bjp_upd_rob_id, i_bjp_upd_bus, i_iq_upd_rdy,
        output o_flush_vld, o_flush_rob_id, o_flush_addr, o_flush_is_ls,
        output o_iq_upd_vld, o_iq_upd_bus, o_bjp_issue_stall
    );
    modport master (
        output i_csr_trap_flush, i_bjp_mis_flush, i_bjp_mis_rob_id, i_bjp_mis_addr,
        output i_exu_ls_flush, i_exu_ls_rob_id, i_exu_ls_addr,
        output i_bjp_upd_vld, i_bjp_upd_rob_id, i_bjp_upd_bus, i_iq_upd_rdy,
        input  o_flush_vld, o_flush_rob_id, o_flush_addr, o_flush_is_ls,
        input  o_iq_upd_vld, o_iq_upd_bus, o_bjp_issue_stall
    );
`endif
endinterface

// File: rtl/bjp_resolve_sched.sv
// Oldest-first redirect arbiter with post-flush suppression window and predictor-update FIFO.
// Optional statistics counters are built when BJP_SCHED_STAT_EN is defined.
module bjp_resolve_sched_chk (
    input logic clk,
    input logic rst_n,
    input logic upd_ovf
);
    // A push finding no free slot means upstream ignored o_bjp_issue_stall.
    a_upd_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !upd_ovf);
endmodule

module bjp_resolve_sched #(
    parameter int NUM_BJP      = 2,
    parameter int ROB_ID_WIDTH = 8,
    parameter int PC_WIDTH     = 32,
    parameter int UPD_WIDTH    = 85,
    parameter int UPD_DEPTH    = 4,
    parameter int FLUSH_HOLD   = 2
) (
    input logic                clk,
    input logic                rst_n,
    bjp_resolve_sched_if.slave bus
);
    localparam int AW = $clog2(UPD_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FLUSH_HOLD + 1) + 1;
    localparam int RM = ROB_ID_WIDTH - 1;
    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_HOLD   = 1'b1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(FLUSH_HOLD);
    localparam logic [PW:0]   DEPTH_W   = (PW+1)'(UPD_DEPTH);

    function automatic logic older(input logic [ROB_ID_WIDTH-1:0] a, input logic [ROB_ID_WIDTH-1:0] b);
        logic res;
        if (a[RM] ^ b[RM]) res = (a[RM-1:0] >= b[RM-1:0]);
        else               res = (a[RM-1:0] <  b[RM-1:0]);
        return res;
    endfunction

    // An LSU flush re-executes its own ROB id, so the equal-id branch is wrong-path too.
    function automatic logic upd_killed(input logic [ROB_ID_WIDTH-1:0] upd_id,
                                        input logic [ROB_ID_WIDTH-1:0] fl_id, input logic fl_is_ls);
        return older(fl_id, upd_id) || (fl_is_ls && (upd_id == fl_id));
    endfunction

    logic [0:0]              state_r;
    logic [CW-1:0]           hold_ctr_r;
    logic [ROB_ID_WIDTH-1:0] hold_id_r;
    logic                    hold_is_ls_r;
    logic                    flush_vld_r, flush_is_ls_r;
    logic [ROB_ID_WIDTH-1:0] flush_rob_id_r;
    logic [PC_WIDTH-1:0]     flush_addr_r;
    logic [UPD_WIDTH-1:0]    mem_r [UPD_DEPTH];
    logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
    logic                    stall_r;

    logic                    trap_s, sel_vld_s, sel_is_ls_s, accept_s, issue_s;
    logic [ROB_ID_WIDTH-1:0] sel_id_s;
    logic [PC_WIDTH-1:0]     sel_addr_s;
    logic [NUM_BJP-1:0]      upd_keep_s, push_en_s;
    logic [AW-1:0]           push_off_s [NUM_BJP];
    logic [PW:0]             free_s, push_cnt_s;
    logic                    upd_ovf_s, pop_s, empty_s, stall_nxt_s;
    logic [PW-1:0]           cnt_s, wr_ptr_nxt_s, rd_ptr_nxt_s, cnt_nxt_s;

    assign trap_s       = bus.i_csr_trap_flush;
    assign empty_s      = (wr_ptr_r == rd_ptr_r);
    assign cnt_s        = wr_ptr_r - rd_ptr_r;
    assign wr_ptr_nxt_s = wr_ptr_r + push_cnt_s[PW-1:0];
    assign rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
    assign cnt_nxt_s    = wr_ptr_nxt_s - rd_ptr_nxt_s;
    assign stall_nxt_s  = (DEPTH_W - {1'b0, cnt_nxt_s}) < (PW+1)'(NUM_BJP);

    // Oldest valid redirect; LSU seeds the scan so it wins ties, then lower BJP index wins.
    always_comb begin
        sel_vld_s   = bus.i_exu_ls_flush;
        sel_is_ls_s = bus.i_exu_ls_flush;
        sel_id_s    = bus.i_exu_ls_rob_id;
        sel_addr_s  = bus.i_exu_ls_addr;
        for (int k = 0; k < NUM_BJP; k++) begin
            if (bus.i_bjp_mis_flush[k] &&
                (!sel_vld_s || older(bus.i_bjp_mis_rob_id[k*ROB_ID_WIDTH +: ROB_ID_WIDTH], sel_id_s))) begin
                sel_vld_s   = 1'b1;
                sel_is_ls_s = 1'b0;
                sel_id_s    = bus.i_bjp_mis_rob_id[k*ROB_ID_WIDTH +: ROB_ID_WIDTH];
                sel_addr_s  = bus.i_bjp_mis_addr[k*PC_WIDTH +: PC_WIDTH];
            end else begin
                sel_vld_s   = sel_vld_s;
            end
        end
    end

    // Suppression: while holding, only a redirect that is truly older than the held one may pass.
    always_comb begin
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: accept_s = sel_vld_s;
            ST_HOLD: accept_s = sel_vld_s && (older(sel_id_s, hold_id_r) ||
                                (sel_is_ls_s && !hold_is_ls_r && (sel_id_s == hold_id_r)));
            default: accept_s = 1'b0;
        endcase
        issue_s = accept_s && !trap_s;
    end

    // Update filtering and slot allocation in unit index order.
    always_comb begin
        pop_s      = !empty_s && bus.i_iq_upd_rdy;
        free_s     = DEPTH_W - {1'b0, cnt_s} + {{PW{1'b0}}, pop_s};
        push_cnt_s = '0;
        upd_ovf_s  = 1'b0;
        for (int k = 0; k < NUM_BJP; k++) begin
            push_en_s[k]  = 1'b0;
            push_off_s[k] = '0;
            upd_keep_s[k] = bus.i_bjp_upd_vld[k] && !trap_s
                && !(issue_s && upd_killed(bus.i_bjp_upd_rob_id[k*ROB_ID_WIDTH +: ROB_ID_WIDTH], sel_id_s, sel_is_ls_s))
                && !((state_r == ST_HOLD) &&
                     upd_killed(bus.i_bjp_upd_rob_id[k*ROB_ID_WIDTH +: ROB_ID_WIDTH], hold_id_r, hold_is_ls_r));
            if (upd_keep_s[k] && (push_cnt_s < free_s)) begin
                push_en_s[k]  = 1'b1;
                push_off_s[k] = push_cnt_s[AW-1:0];
                push_cnt_s    = push_cnt_s + (PW+1)'(1);
            end else if (upd_keep_s[k]) begin
                upd_ovf_s     = 1'b1;
            end else begin
                push_en_s[k]  = 1'b0;
            end
        end
    end

    // Redirect FSM and registered flush outputs; a trap overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;  hold_ctr_r <= '0;  hold_id_r <= '0;  hold_is_ls_r <= 1'b0;
            flush_vld_r <= 1'b0; flush_rob_id_r <= '0; flush_addr_r <= '0; flush_is_ls_r <= 1'b0;
        end else if (trap_s) begin
            state_r <= ST_IDLE;  hold_ctr_r <= '0;  flush_vld_r <= 1'b0;
        end else begin
            flush_vld_r <= issue_s;
            if (issue_s) begin
                flush_rob_id_r <= sel_id_s;  flush_addr_r <= sel_addr_s;  flush_is_ls_r <= sel_is_ls_s;
                hold_id_r      <= sel_id_s;  hold_is_ls_r <= sel_is_ls_s;
                hold_ctr_r     <= HOLD_LOAD; state_r      <= ST_HOLD;
            end else begin
                case (state_r)
                    ST_HOLD: begin
                        hold_ctr_r <= (hold_ctr_r > CW'(1)) ? hold_ctr_r - CW'(1) : '0;
                        state_r    <= (hold_ctr_r > CW'(1)) ? ST_HOLD : ST_IDLE;
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

    // FIFO pointers and registered issue stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;  rd_ptr_r <= '0;  stall_r <= 1'b0;
        end else if (trap_s) begin
            wr_ptr_r <= '0;  rd_ptr_r <= '0;  stall_r <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;  rd_ptr_r <= rd_ptr_nxt_s;  stall_r <= stall_nxt_s;
        end
    end

    // FIFO storage writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < UPD_DEPTH; i++) mem_r[i] <= '0;
        end else begin
            for (int k = 0; k < NUM_BJP; k++) begin
                if (push_en_s[k]) mem_r[wr_ptr_r[AW-1:0] + push_off_s[k]] <= bus.i_bjp_upd_bus[k*UPD_WIDTH +: UPD_WIDTH];
            end
        end
    end

    assign bus.o_flush_vld       = flush_vld_r;
    assign bus.o_flush_rob_id    = flush_rob_id_r;
    assign bus.o_flush_addr      = flush_addr_r;
    assign bus.o_flush_is_ls     = flush_is_ls_r;
    assign bus.o_iq_upd_vld      = !empty_s;
    assign bus.o_iq_upd_bus      = mem_r[rd_ptr_r[AW-1:0]];
    assign bus.o_bjp_issue_stall = stall_r;

`ifdef BJP_SCHED_STAT_EN
    logic [31:0] stat_flush_cnt_r, stat_drop_cnt_r;
    logic [3:0]  drop_evt_s;
    logic [32:0] drop_sum_s;

    // Rejected redirects plus updates that did not make it into the FIFO this cycle.
    always_comb begin
        drop_evt_s = 4'd0;
        if (!trap_s) begin
            for (int k = 0; k < NUM_BJP; k++) begin
                drop_evt_s = drop_evt_s + {3'd0, bus.i_bjp_mis_flush[k]} + {3'd0, bus.i_bjp_upd_vld[k] && !push_en_s[k]};
            end
            drop_evt_s = drop_evt_s + {3'd0, bus.i_exu_ls_flush} - {3'd0, issue_s};
        end else begin
            drop_evt_s = 4'd0;
        end
    end
    assign drop_sum_s = {1'b0, stat_drop_cnt_r} + {29'd0, drop_evt_s};

    // Saturating statistics; intentionally survive trap flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_flush_cnt_r <= 32'd0;
            stat_drop_cnt_r  <= 32'd0;
        end else begin
            if (issue_s && (stat_flush_cnt_r != 32'hFFFF_FFFF)) stat_flush_cnt_r <= stat_flush_cnt_r + 32'd1;
            stat_drop_cnt_r <= drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
        end
    end
    assign bus.o_stat_flush_cnt = stat_flush_cnt_r;
    assign bus.o_stat_drop_cnt  = stat_drop_cnt_r;
`endif

    bjp_resolve_sched_chk u_chk (.clk(clk), .rst_n(rst_n), .upd_ovf(upd_ovf_s && !trap_s));
endmodule

// File: tb/tb_bjp_resolve_sched.sv
// Directed self-checking bench for bjp_resolve_sched (default configuration).
module tb_bjp_resolve_sched;
    localparam int NB = 2, W = 8, PCW = 32, UW = 85;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    bjp_resolve_sched_if #(.NUM_BJP(NB), .ROB_ID_WIDTH(W), .PC_WIDTH(PCW), .UPD_WIDTH(UW)) bus ();
    bjp_resolve_sched #(.NUM_BJP(NB), .ROB_ID_WIDTH(W), .PC_WIDTH(PCW), .UPD_WIDTH(UW),
                        .UPD_DEPTH(4), .FLUSH_HOLD(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic clr();
        bus.i_csr_trap_flush = 1'b0;  bus.i_bjp_mis_flush = '0;  bus.i_bjp_mis_rob_id = '0;
        bus.i_bjp_mis_addr = '0;      bus.i_exu_ls_flush = 1'b0; bus.i_exu_ls_rob_id = '0;
        bus.i_exu_ls_addr = '0;       bus.i_bjp_upd_vld = '0;    bus.i_bjp_upd_rob_id = '0;
        bus.i_bjp_upd_bus = '0;       bus.i_iq_upd_rdy = 1'b0;
    endtask
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic idle(input int n);
        clr(); repeat (n) tick();
    endtask
    task automatic set_mis(input int k, input logic [W-1:0] id, input logic [PCW-1:0] a);
        bus.i_bjp_mis_flush[k] = 1'b1; bus.i_bjp_mis_rob_id[k*W +: W] = id; bus.i_bjp_mis_addr[k*PCW +: PCW] = a;
    endtask
    task automatic set_ls(input logic [W-1:0] id, input logic [PCW-1:0] a);
        bus.i_exu_ls_flush = 1'b1; bus.i_exu_ls_rob_id = id; bus.i_exu_ls_addr = a;
    endtask
    task automatic set_upd(input int k, input logic [W-1:0] id, input logic [UW-1:0] d);
        bus.i_bjp_upd_vld[k] = 1'b1; bus.i_bjp_upd_rob_id[k*W +: W] = id; bus.i_bjp_upd_bus[k*UW +: UW] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr(); #2;
        n_checks++; if (bus.o_flush_vld !== 1'b0) begin n_fail++; $display("FAIL reset_flush_vld: got %b want 0", bus.o_flush_vld); end
        n_checks++; if (bus.o_flush_rob_id !== 8'h00) begin n_fail++; $display("FAIL reset_rob_id: got %h want 00", bus.o_flush_rob_id); end
        n_checks++; if (bus.o_flush_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.o_flush_addr); end
        n_checks++; if (bus.o_flush_is_ls !== 1'b0) begin n_fail++; $display("FAIL reset_is_ls: got %b want 0", bus.o_flush_is_ls); end
        n_checks++; if (bus.o_iq_upd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_upd_vld: got %b want 0", bus.o_iq_upd_vld); end
        n_checks++; if (bus.o_bjp_issue_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.o_bjp_issue_stall); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        clr(); set_mis(0, 8'h05, 32'h0000_1000); tick(); clr();
        n_checks++; if (bus.o_flush_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld: got %b want 1", bus.o_flush_vld); end
        n_checks++; if (bus.o_flush_rob_id !== 8'h05) begin n_fail++; $display("FAIL single_id: got %h want 05", bus.o_flush_rob_id); end
        n_checks++; if (bus.o_flush_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL single_addr: got %h want 00001000", bus.o_flush_addr); end
        n_checks++; if (bus.o_flush_is_ls !== 1'b0) begin n_fail++; $display("FAIL single_is_ls: got %b want 0", bus.o_flush_is_ls); end
        tick();
        n_checks++; if (bus.o_flush_vld !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", bus.o_flush_vld); end
        idle(3);
    endtask

    task automatic test_arbitration();
        // 0x7F (wrap 0, idx 127) was allocated before 0x85/0x90 (wrap 1) and is the oldest.
        clr(); set_mis(0, 8'h85, 32'h0000_0A00); set_mis(1, 8'h7F, 32'h0000_0A01); set_ls(8'h90, 32'h0000_0A02);
        tick(); clr();
        n_checks++; if (bus.o_flush_rob_id !== 8'h7F) begin n_fail++; $display("FAIL arb_wrap_id: got %h want 7f", bus.o_flush_rob_id); end
        n_checks++; if (bus.o_flush_addr !== 32'h0000_0A01) begin n_fail++; $display("FAIL arb_wrap_addr: got %h want 00000a01", bus.o_flush_addr); end
        idle(3);
        clr(); set_mis(0, 8'h30, 32'h0000_0B00); set_mis(1, 8'h30, 32'h0000_0B01); tick(); clr();
        n_checks++; if (bus.o_flush_addr !== 32'h0000_0B00) begin n_fail++; $display("FAIL arb_tie_addr: got %h want 00000b00", bus.o_flush_addr); end
        idle(3);
    endtask

    task automatic test_suppress();
        clr(); set_mis(0, 8'h10, 32'h0000_0100); tick();
        clr(); set_mis(1, 8'h12, 32'h0000_0120);
        n_checks++; if (bus.o_flush_rob_id !== 8'h10) begin n_fail++; $display("FAIL supp_first_id: got %h want 10", bus.o_flush_rob_id); end
        tick(); clr(); set_ls(8'h0E, 32'h0000_00E0);
        n_checks++; if (bus.o_flush_vld !== 1'b0) begin n_fail++; $display("FAIL supp_younger_dropped: got %b want 0", bus.o_flush_vld); end
        tick(); clr();
        n_checks++; if (bus.o_flush_vld !== 1'b1) begin n_fail++; $display("FAIL supp_older_vld: got %b want 1", bus.o_flush_vld); end
        n_checks++; if (bus.o_flush_rob_id !== 8'h0E) begin n_fail++; $display("FAIL supp_older_id: got %h want 0e", bus.o_flush_rob_id); end
        n_checks++; if (bus.o_flush_is_ls !== 1'b1) begin n_fail++; $display("FAIL supp_older_is_ls: got %b want 1", bus.o_flush_is_ls); end
        idle(3);
        // Window covers the 2 cycles after the issue cycle, then reopens.
        clr(); set_mis(0, 8'h40, 32'h0000_0400); tick(); clr(); tick();
        set_mis(0, 8'h48, 32'h0000_0480); tick(); clr(); set_mis(0, 8'h50, 32'h0000_0500);
        n_checks++; if (bus.o_flush_vld !== 1'b0) begin n_fail++; $display("FAIL hold_last_cycle_drop: got %b want 0", bus.o_flush_vld); end
        tick(); clr();
        n_checks++; if (bus.o_flush_vld !== 1'b1 || bus.o_flush_rob_id !== 8'h50) begin
            n_fail++; $display("FAIL hold_expired_accept: got vld %b id %h want 1/50", bus.o_flush_vld, bus.o_flush_rob_id); end
        idle(3);
    endtask

    task automatic test_ls_equal();
        clr(); set_mis(0, 8'h20, 32'h0000_2004); set_ls(8'h20, 32'h0000_2000);
        set_upd(0, 8'h20, 85'h1_0000_0000_0000_0000_0C01); set_upd(1, 8'h1F, 85'h1_0000_0000_0000_0000_0C02);
        tick(); clr();
        n_checks++; if (bus.o_flush_rob_id !== 8'h20 || bus.o_flush_is_ls !== 1'b1) begin
            n_fail++; $display("FAIL lseq_flush: got id %h is_ls %b want 20/1", bus.o_flush_rob_id, bus.o_flush_is_ls); end
        n_checks++; if (bus.o_flush_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL lseq_addr: got %h want 00002000", bus.o_flush_addr); end
        n_checks++; if (bus.o_iq_upd_vld !== 1'b1 || bus.o_iq_upd_bus !== 85'h1_0000_0000_0000_0000_0C02) begin
            n_fail++; $display("FAIL lseq_head: got vld %b bus %h want 1/..0c02", bus.o_iq_upd_vld, bus.o_iq_upd_bus); end
        bus.i_iq_upd_rdy = 1'b1; tick(); clr();
        n_checks++; if (bus.o_iq_upd_vld !== 1'b0) begin n_fail++; $display("FAIL lseq_equal_dropped: got %b want 0", bus.o_iq_upd_vld); end
        idle(3);
    endtask

    task automatic test_upd_filter();
        clr(); set_mis(1, 8'h60, 32'h0000_0600);
        set_upd(0, 8'h61, 85'h1_0000_0000_0000_0000_0D01); set_upd(1, 8'h60, 85'h1_0000_0000_0000_0000_0D02);
        tick(); clr();
        set_ls(8'h60, 32'h0000_0660);
        set_upd(0, 8'h62, 85'h1_0000_0000_0000_0000_0D03); set_upd(1, 8'h5F, 85'h1_0000_0000_0000_0000_0D04);
        n_checks++; if (bus.o_iq_upd_bus !== 85'h1_0000_0000_0000_0000_0D02) begin n_fail++; $display("FAIL filt_keep_equal: got %h want ..0d02", bus.o_iq_upd_bus); end
        tick(); clr(); bus.i_iq_upd_rdy = 1'b1;
        n_checks++; if (bus.o_flush_vld !== 1'b1 || bus.o_flush_is_ls !== 1'b1 || bus.o_flush_rob_id !== 8'h60) begin
            n_fail++; $display("FAIL filt_ls_at_hold: got vld %b is_ls %b id %h want 1/1/60", bus.o_flush_vld, bus.o_flush_is_ls, bus.o_flush_rob_id); end
        tick();
        n_checks++; if (bus.o_iq_upd_vld !== 1'b1 || bus.o_iq_upd_bus !== 85'h1_0000_0000_0000_0000_0D04) begin
            n_fail++; $display("FAIL filt_second_head: got vld %b bus %h want 1/..0d04", bus.o_iq_upd_vld, bus.o_iq_upd_bus); end
        tick();
        n_checks++; if (bus.o_iq_upd_vld !== 1'b0) begin n_fail++; $display("FAIL filt_empty: got %b want 0", bus.o_iq_upd_vld); end
        idle(3);
    endtask

    task automatic test_fifo_full();
        logic [UW-1:0] bv [5];
        logic [3:0]    st_exp;
        st_exp = 4'b0001;
        for (int i = 0; i < 5; i++) bv[i] = 85'h1_0000_0000_0000_0000_0E00 + UW'(i);
        clr(); set_upd(0, 8'h01, bv[0]); set_upd(1, 8'h02, bv[1]); tick();
        n_checks++; if (bus.o_bjp_issue_stall !== 1'b0) begin n_fail++; $display("FAIL full_stall_occ2: got %b want 0", bus.o_bjp_issue_stall); end
        clr(); set_upd(0, 8'h03, bv[2]); set_upd(1, 8'h04, bv[3]); tick();
        n_checks++; if (bus.o_bjp_issue_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall_occ4: got %b want 1", bus.o_bjp_issue_stall); end
        n_checks++; if (bus.o_iq_upd_bus !== bv[0]) begin n_fail++; $display("FAIL full_head0: got %h want %h", bus.o_iq_upd_bus, bv[0]); end
        clr(); bus.i_iq_upd_rdy = 1'b1; set_upd(0, 8'h05, bv[4]); tick();
        n_checks++; if (bus.o_bjp_issue_stall !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_stall: got %b want 1", bus.o_bjp_issue_stall); end
        clr(); bus.i_iq_upd_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.o_iq_upd_bus !== bv[i+1]) begin n_fail++; $display("FAIL full_order_%0d: got %h want %h", i, bus.o_iq_upd_bus, bv[i+1]); end
            tick();
            n_checks++; if (bus.o_bjp_issue_stall !== st_exp[i]) begin n_fail++; $display("FAIL full_drain_stall_%0d: got %b want %b", i, bus.o_bjp_issue_stall, st_exp[i]); end
        end
        n_checks++; if (bus.o_iq_upd_vld !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", bus.o_iq_upd_vld); end
        idle(2);
    endtask

    task automatic test_trap();
        clr(); set_upd(0, 8'h01, 85'h1_0000_0000_0000_0000_0F01); tick();
        clr(); set_mis(0, 8'h70, 32'h0000_7000);
        set_upd(0, 8'h02, 85'h1_0000_0000_0000_0000_0F02); set_upd(1, 8'h03, 85'h1_0000_0000_0000_0000_0F03); tick();
        clr();
        n_checks++; if (bus.o_flush_rob_id !== 8'h70 || bus.o_bjp_issue_stall !== 1'b1) begin
            n_fail++; $display("FAIL trap_pre: got id %h stall %b want 70/1", bus.o_flush_rob_id, bus.o_bjp_issue_stall); end
        bus.i_csr_trap_flush = 1'b1; set_mis(0, 8'h00, 32'h0000_0000); set_upd(1, 8'h04, 85'h1_0000_0000_0000_0000_0F04);
        tick(); clr();
        n_checks++; if (bus.o_flush_vld !== 1'b0) begin n_fail++; $display("FAIL trap_flush_vld: got %b want 0", bus.o_flush_vld); end
        n_checks++; if (bus.o_iq_upd_vld !== 1'b0) begin n_fail++; $display("FAIL trap_fifo_empty: got %b want 0", bus.o_iq_upd_vld); end
        n_checks++; if (bus.o_bjp_issue_stall !== 1'b0) begin n_fail++; $display("FAIL trap_stall: got %b want 0", bus.o_bjp_issue_stall); end
        set_mis(1, 8'h75, 32'h0000_7500); tick(); clr();
        n_checks++; if (bus.o_flush_vld !== 1'b1 || bus.o_flush_rob_id !== 8'h75) begin
            n_fail++; $display("FAIL trap_fsm_idle: got vld %b id %h want 1/75", bus.o_flush_vld, bus.o_flush_rob_id); end
        idle(3);
    endtask

    task automatic test_mid_reset();
        clr(); set_mis(0, 8'h05, 32'h0000_0050); set_upd(0, 8'h01, 85'h1_0000_0000_0000_0000_0A0A); tick(); clr();
        #2 rst_n = 1'b0; #1;
        n_checks++; if (bus.o_flush_vld !== 1'b0 || bus.o_flush_rob_id !== 8'h00) begin
            n_fail++; $display("FAIL midrst_flush: got vld %b id %h want 0/00", bus.o_flush_vld, bus.o_flush_rob_id); end
        n_checks++; if (bus.o_iq_upd_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_fifo: got %b want 0", bus.o_iq_upd_vld); end
        @(negedge clk); rst_n = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_suppress();
        test_ls_equal();
        test_upd_filter();
        test_fifo_full();
        test_trap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
